// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, operand typedefs and signed range helpers for the PE
package pe_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ACC_W  = 16;

  typedef logic signed [DEFAULT_DATA_W-1:0]   operand_t;
  typedef logic signed [DEFAULT_DATA_W-1:0]   weight_t;
  typedef logic signed [2*DEFAULT_DATA_W-1:0] product_t;

  function automatic logic signed [63:0] signed_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] signed_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/pe_sat_clamp.sv
// rtl/pe_sat_clamp.sv - resize the wide PE sum to ACC_W; clamps when PE_SATURATE_EN is defined, wraps otherwise
module pe_sat_clamp
  import pe_pkg::*;
#(
  parameter int SUM_W = 17,
  parameter int ACC_W = 16
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic signed [ACC_W-1:0] psum,
  output logic                    sat
);
`ifdef PE_SATURATE_EN
  localparam logic signed [63:0] MAX_V = signed_max(ACC_W);
  localparam logic signed [63:0] MIN_V = signed_min(ACC_W);

  logic signed [63:0] sum_ext;
  assign sum_ext = 64'(sum);

  always_comb begin
    psum = sum[ACC_W-1:0];
    sat  = 1'b0;
    if (sum_ext > MAX_V) begin
      psum = MAX_V[ACC_W-1:0];
      sat  = 1'b1;
    end else if (sum_ext < MIN_V) begin
      psum = MIN_V[ACC_W-1:0];
      sat  = 1'b1;
    end
  end
`else
  // Two's-complement wrap: the high bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^sum[SUM_W-1:ACC_W];
  assign psum      = sum[ACC_W-1:0];
  assign sat       = 1'b0;
`endif
endmodule

// File: rtl/pe_weight_stationary.sv
// rtl/pe_weight_stationary.sv - double-buffered weight-stationary MAC PE, 2-stage pipeline
// Optional clamping of psum_out is enabled by defining PE_SATURATE_EN.
module pe_weight_stationary
  import pe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_valid_out,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic                     out_valid,
  input  logic                     w_shift,
  input  logic signed [DATA_W-1:0] w_in,
  output logic signed [DATA_W-1:0] w_out,
  input  logic                     w_swap,
  output logic                     sat_out
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  logic signed [DATA_W-1:0] w_active;
  logic signed [DATA_W-1:0] w_shadow;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [ACC_W-1:0]  psum_r;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  psum_fit;
  logic                     sat_fit;

  assign w_out = w_shadow;

  // Swap reads the pre-edge shadow, so a same-edge shift never leaks into active.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w_active <= '0;
      w_shadow <= '0;
    end else begin
      if (w_swap)  w_active <= w_shadow;
      if (w_shift) w_shadow <= w_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prod_r      <= '0;
      psum_r      <= '0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
    end else begin
      a_valid_out <= in_valid;
      if (in_valid) begin
        prod_r <= PROD_W'(w_active) * PROD_W'(a_in);
        psum_r <= psum_in;
        a_out  <= a_in;
      end
    end
  end

  assign sum = SUM_W'(prod_r) + SUM_W'(psum_r);

  pe_sat_clamp #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) u_clamp (
    .sum  (sum),
    .psum (psum_fit),
    .sat  (sat_fit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      psum_out  <= '0;
      out_valid <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      out_valid <= a_valid_out;
      sat_out   <= a_valid_out & sat_fit;
      if (a_valid_out) psum_out <= psum_fit;
    end
  end
endmodule

// File: tb/tb_pe_weight_stationary.sv
// tb/tb_pe_weight_stationary.sv - randomized and directed check of pe_weight_stationary against an arithmetic model
module tb_pe_weight_stationary;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [2:0]       iv, ws, sw;
  logic [2:0][7:0]  a, wi;
  logic [2:0][15:0] pin;
  wire  [2:0][7:0]  aout, wout;
  wire  [2:0]       av, ov, sat;
  wire  [15:0]      ps0, ps1;
  wire  [7:0]       ps8;

  pe_weight_stationary #(.DATA_W(8), .ACC_W(16)) pe0 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv[0]), .a_in(a[0]), .psum_in(pin[0]),
    .a_out(aout[0]), .a_valid_out(av[0]), .psum_out(ps0), .out_valid(ov[0]),
    .w_shift(ws[0]), .w_in(wi[0]), .w_out(wout[0]), .w_swap(sw[0]), .sat_out(sat[0]));

  pe_weight_stationary #(.DATA_W(8), .ACC_W(16)) pe1 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv[1]), .a_in(a[1]), .psum_in(pin[1]),
    .a_out(aout[1]), .a_valid_out(av[1]), .psum_out(ps1), .out_valid(ov[1]),
    .w_shift(ws[1]), .w_in(wout[0]), .w_out(wout[1]), .w_swap(sw[1]), .sat_out(sat[1]));

  pe_weight_stationary #(.DATA_W(8), .ACC_W(8)) pe8 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv[2]), .a_in(a[2]), .psum_in(pin[2][7:0]),
    .a_out(aout[2]), .a_valid_out(av[2]), .psum_out(ps8), .out_valid(ov[2]),
    .w_shift(ws[2]), .w_in(wi[2]), .w_out(wout[2]), .w_swap(sw[2]), .sat_out(sat[2]));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v, input int w);
    return (w == 8) ? longint'($signed(v[7:0])) : longint'($signed(v));
  endfunction

  // Reference model: plain integers per PE.
  int     accw[3] = '{16, 16, 8};
  longint m_act[3], m_sh[3], m_aout[3], m_pend[3], m_psum[3];
  bit     m_av[3], m_pv[3], m_ov[3], m_sat[3];

  task automatic fit(input longint s, input int w, output longint r, output bit st);
    longint mx, mn, span;
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -mx - 1;
    span = longint'(1) << w;
`ifdef PE_SATURATE_EN
    if (s > mx)      begin r = mx; st = 1'b1; end
    else if (s < mn) begin r = mn; st = 1'b1; end
    else             begin r = s;  st = 1'b0; end
`else
    r = s & (span - 1);
    if (r > mx) r = r - span;
    st = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_act[p] = 0; m_sh[p] = 0; m_aout[p] = 0; m_pend[p] = 0; m_psum[p] = 0;
      m_av[p] = 0; m_pv[p] = 0; m_ov[p] = 0; m_sat[p] = 0;
    end
  endtask

  task automatic model_edge();
    longint sh0_old, win, r;
    bit st;
    sh0_old = m_sh[0];
    for (int p = 0; p < 3; p++) begin
      win = (p == 1) ? sh0_old : sx({8'h00, wi[p]}, 8);
      if (m_pv[p]) begin
        fit(m_pend[p], accw[p], r, st);
        m_psum[p] = r; m_sat[p] = st; m_ov[p] = 1'b1;
      end else begin
        m_ov[p] = 1'b0; m_sat[p] = 1'b0;
      end
      if (iv[p]) begin
        m_pend[p] = m_act[p] * sx({8'h00, a[p]}, 8) + sx(pin[p], accw[p]);
        m_pv[p] = 1'b1; m_aout[p] = sx({8'h00, a[p]}, 8); m_av[p] = 1'b1;
      end else begin
        m_pv[p] = 1'b0; m_av[p] = 1'b0;
      end
      if (sw[p]) m_act[p] = m_sh[p];
      if (ws[p]) m_sh[p] = win;
    end
  endtask

  task automatic check_all();
    longint ps;
    for (int p = 0; p < 3; p++) begin
      ps = (p == 0) ? sx(ps0, 16) : (p == 1) ? sx(ps1, 16) : sx({8'h00, ps8}, 8);
      check($sformatf("a_out%0d", p), sx({8'h00, aout[p]}, 8), m_aout[p]);
      check($sformatf("a_valid%0d", p), longint'(av[p]), longint'(m_av[p]));
      check($sformatf("psum%0d", p), ps, m_psum[p]);
      check($sformatf("out_valid%0d", p), longint'(ov[p]), longint'(m_ov[p]));
      check($sformatf("sat%0d", p), longint'(sat[p]), longint'(m_sat[p]));
      check($sformatf("w_out%0d", p), sx({8'h00, wout[p]}, 8), m_sh[p]);
    end
  endtask

  task automatic idle();
    iv = '0; ws = '0; sw = '0; a = '0; wi = '0; pin = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic mid_cycle_reset();
    @(posedge clk);
    model_edge();
    #2 n_rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    idle();
    n_rst = 1'b1;
    step();
    step();
  endtask

  task automatic load_w(input int p, input logic [7:0] w);
    idle(); ws[p] = 1'b1; wi[p] = w; step();
    idle(); sw[p] = 1'b1; step();
    idle();
  endtask

  task automatic sample(input int p, input logic [7:0] av_in, input logic [15:0] ps_in);
    idle(); iv[p] = 1'b1; a[p] = av_in; pin[p] = ps_in; step();
    idle(); step();
  endtask

  initial begin
    n_rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    n_rst = 1'b1;
    step();

    load_w(0, 8'd2);
    idle(); iv[0] = 1'b1; a[0] = 8'd5; pin[0] = 16'd6; step();
    check("mac_a_out", sx({8'h00, aout[0]}, 8), 5);
    idle(); step();
    check("mac_pos", sx(ps0, 16), 16);
    check("mac_pos_valid", longint'(ov[0]), 1);

    load_w(0, 8'hFB);
    sample(0, 8'd6, 16'hFFF9);
    check("mac_neg", sx(ps0, 16), -37);

    idle(); ws[0] = 1'b1; wi[0] = 8'd3; step();
    idle(); ws[0] = 1'b1; sw[0] = 1'b1; wi[0] = 8'd4; step();
    idle(); iv[0] = 1'b1; a[0] = 8'd1; sw[0] = 1'b1; step();
    idle(); iv[0] = 1'b1; a[0] = 8'd1; step();
    check("swap_old", sx(ps0, 16), 3);
    idle(); step();
    check("swap_new", sx(ps0, 16), 4);

    load_w(2, 8'h80);
    sample(2, 8'h80, 16'd100);
`ifdef PE_SATURATE_EN
    check("clamp_hi", sx({8'h00, ps8}, 8), 127);
    check("clamp_hi_sat", longint'(sat[2]), 1);
`else
    check("wrap_hi", sx({8'h00, ps8}, 8), 100);
    check("wrap_hi_sat", longint'(sat[2]), 0);
`endif
    load_w(2, 8'd100);
    sample(2, 8'h9C, 16'h00F6);
`ifdef PE_SATURATE_EN
    check("clamp_lo", sx({8'h00, ps8}, 8), -128);
`else
    check("wrap_lo", sx({8'h00, ps8}, 8), -26);
`endif
    load_w(2, 8'd2);
    sample(2, 8'd5, 16'd6);
    check("fit_ok", sx({8'h00, ps8}, 8), 16);
    check("fit_ok_sat", longint'(sat[2]), 0);

    idle(); ws[0] = 1'b1; ws[1] = 1'b1; wi[0] = 8'd7; step();
    idle(); ws[0] = 1'b1; ws[1] = 1'b1; wi[0] = 8'd9; step();
    check("chain_pe0", sx({8'h00, wout[0]}, 8), 9);
    check("chain_pe1", sx({8'h00, wout[1]}, 8), 7);
    idle(); ws[0] = 1'b1; sw[0] = 1'b1; wi[0] = 8'd11; step();
    check("shift_swap_shadow", sx({8'h00, wout[0]}, 8), 11);
    sample(0, 8'd1, 16'd0);
    check("shift_swap_active", sx(ps0, 16), 9);

    idle(); iv = '1; a = '{8'd3, 8'd4, 8'd5}; pin = '{16'd1, 16'd2, 16'd3};
    mid_cycle_reset();
    check("post_reset_valid", longint'(ov[0]), 0);

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) begin
        iv[p]  = ($urandom_range(3) != 0);
        ws[p]  = $urandom_range(1);
        sw[p]  = ($urandom_range(3) == 0);
        a[p]   = 8'($urandom);
        wi[p]  = 8'($urandom);
        pin[p] = 16'($urandom);
      end
      if (c == 200) mid_cycle_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
